// File: rtl/cdc_handshake_tx_if.sv
// Source-side signal bundle of the 4-phase REQ/ACK CDC channel.
// SRC_VALID/SRC_READY: a word moves on a CLK edge where both are high; SRC_DATA must hold while SRC_VALID waits.
interface cdc_handshake_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] SRC_DATA;
    logic                  SRC_VALID;
    logic                  SRC_READY;
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_REQ;
    logic                  ACK_IN;
    logic                  BUSY;
    logic                  DONE;
    logic                  TIMEOUT;
    logic [1:0]            state_dbg;

    modport master (
        output SRC_DATA, SRC_VALID, ACK_IN,
        input  SRC_READY, TX_DATA, TX_REQ, BUSY, DONE, TIMEOUT, state_dbg
    );

    modport slave (
        input  SRC_DATA, SRC_VALID, ACK_IN,
        output SRC_READY, TX_DATA, TX_REQ, BUSY, DONE, TIMEOUT, state_dbg
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase REQ/ACK CDC channel: captures a word, raises
// TX_REQ, waits for the synchronized ack to rise and fall, optionally times out.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic              CLK,
    input logic              RST,
    cdc_handshake_tx_if.slave bus
);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  to_q, to_d;
    logic                  acked_q, acked_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                  ack_s;

    // ACK_IN is asynchronous; only the last stage is safe to decode.
    always_ff @(posedge CLK) begin
        if (!RST) ack_sync <= '0;
        else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ACK_IN};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            acked_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            to_q    <= to_d;
            acked_q <= acked_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        acked_d = acked_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.SRC_VALID) begin
                    data_d  = bus.SRC_DATA;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    acked_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack arriving on the terminal-count edge takes priority.
                if (ack_s) begin
                    req_d   = 1'b0;
                    acked_d = 1'b1;
                    state_d = ST_RELEASE;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    acked_d = 1'b0;
                    state_d = ST_RELEASE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    done_d  = acked_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign bus.SRC_READY = (state_q == ST_IDLE);
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.TX_DATA   = data_q;
    assign bus.TX_REQ    = req_q;
    assign bus.DONE      = done_q;
    assign bus.TIMEOUT   = to_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench: bus0 drives an instance without timeout, bus1 an instance
// with TIMEOUT_CYCLES=5; both share clock and reset.
module tb_cdc_handshake_tx;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done0_cnt, done1_cnt, to0_cnt, to1_cnt;
    logic [7:0] exp_q[$];

    cdc_handshake_tx_if #(.DATA_WIDTH(8)) bus0 ();
    cdc_handshake_tx_if #(.DATA_WIDTH(8)) bus1 ();

    cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst_n), .bus(bus0)
    );
    cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(5)) dut1 (
        .CLK(clk), .RST(rst_n), .bus(bus1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus0.DONE === 1'b1)    done0_cnt++;
        if (bus1.DONE === 1'b1)    done1_cnt++;
        if (bus0.TIMEOUT === 1'b1) to0_cnt++;
        if (bus1.TIMEOUT === 1'b1) to1_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.SRC_VALID = 1'b1; bus0.SRC_DATA = 8'hFF; bus0.ACK_IN = 1'b1;
        bus1.SRC_VALID = 1'b1; bus1.SRC_DATA = 8'hFF; bus1.ACK_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus0.TX_REQ !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b want 0", bus0.TX_REQ); end
            checks++;
            if (bus0.TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus0.TX_DATA); end
            checks++;
            if (bus0.SRC_READY !== 1'b1) begin errors++; $display("FAIL reset_src_ready: got %b want 1", bus0.SRC_READY); end
            checks++;
            if (bus0.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus0.DONE); end
            checks++;
            if (bus1.TX_REQ !== 1'b0 || bus1.TIMEOUT !== 1'b0) begin
                errors++; $display("FAIL reset_tx_req_to: got req=%b to=%b want 0 0", bus1.TX_REQ, bus1.TIMEOUT);
            end
        end
        bus0.SRC_VALID = 1'b0; bus0.ACK_IN = 1'b0;
        bus1.SRC_VALID = 1'b0; bus1.ACK_IN = 1'b0;
        rst_n = 1'b1;
        tick();
        done0_cnt = 0; done1_cnt = 0; to0_cnt = 0; to1_cnt = 0;
    endtask

    task automatic test_single();
        int d0;
        d0 = done0_cnt;
        bus0.SRC_DATA = 8'hA5; bus0.SRC_VALID = 1'b1;
        checks++;
        if (bus0.SRC_READY !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus0.SRC_READY); end
        tick();
        bus0.SRC_VALID = 1'b0; bus0.SRC_DATA = 8'h00;
        checks++;
        if (bus0.TX_REQ !== 1'b1 || bus0.TX_DATA !== 8'hA5) begin
            errors++; $display("FAIL single_req_rise: got req=%b data=%h want 1 a5", bus0.TX_REQ, bus0.TX_DATA);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus0.TX_REQ !== 1'b1 || bus0.TX_DATA !== 8'hA5) begin
                errors++; $display("FAIL single_req_hold: got req=%b data=%h want 1 a5", bus0.TX_REQ, bus0.TX_DATA);
            end
        end
        bus0.ACK_IN = 1'b1;
        // two synchronizer edges bring ack_s up, the FSM reacts on the next one
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus0.TX_REQ !== 1'b1) begin errors++; $display("FAIL single_req_sync: got %b want 1", bus0.TX_REQ); end
        end
        tick();
        checks++;
        if (bus0.TX_REQ !== 1'b0 || bus0.state_dbg !== S_REL || bus0.TX_DATA !== 8'hA5) begin
            errors++; $display("FAIL single_req_fall: got req=%b st=%0d data=%h want 0 2 a5", bus0.TX_REQ, bus0.state_dbg, bus0.TX_DATA);
        end
        bus0.ACK_IN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus0.DONE !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", bus0.DONE); end
        end
        tick();
        checks++;
        if (bus0.DONE !== 1'b1 || bus0.SRC_READY !== 1'b1) begin
            errors++; $display("FAIL single_done: got done=%b ready=%b want 1 1", bus0.DONE, bus0.SRC_READY);
        end
        tick();
        checks++;
        if (done0_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done0_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] exp_v;
        logic prev_ready, prev_done;
        int idx, d0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        idx = 0; d0 = done0_cnt;
        exp_q.delete();
        bus0.SRC_DATA = words[0]; bus0.SRC_VALID = 1'b1; bus0.ACK_IN = 1'b0;
        for (int cyc = 0; cyc < 300 && (done0_cnt - d0) < 3; cyc++) begin
            prev_ready = bus0.SRC_READY;
            prev_done  = bus0.DONE;
            tick();
            if (prev_ready && bus0.SRC_VALID) begin
                if (idx > 0) begin
                    checks++;
                    if (prev_done !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_done: got done=%b want 1 (word %0d)", prev_done, idx); end
                end
                exp_q.push_back(words[idx]);
                idx++;
                if (idx < 3) bus0.SRC_DATA = words[idx];
                else         bus0.SRC_VALID = 1'b0;
            end
            if (bus0.DONE === 1'b1) begin
                checks++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                if (bus0.TX_DATA !== exp_v) begin errors++; $display("FAIL b2b_tx_data: got %h want %h", bus0.TX_DATA, exp_v); end
            end
            bus0.ACK_IN = bus0.TX_REQ;
        end
        bus0.SRC_VALID = 1'b0;
        checks++;
        if (done0_cnt - d0 !== 3 || idx !== 3 || exp_q.size() !== 0) begin
            errors++; $display("FAIL b2b_count: got done=%0d accepted=%0d left=%0d want 3 3 0", done0_cnt - d0, idx, exp_q.size());
        end
        bus0.ACK_IN = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [7:0] vals [6];
        int n;
        vals[0] = 8'hC3; vals[1] = 8'h00; vals[2] = 8'hFF;
        vals[3] = 8'h5A; vals[4] = 8'hA5; vals[5] = 8'h01;
        bus0.ACK_IN = 1'b0;
        bus0.SRC_DATA = 8'h3C; bus0.SRC_VALID = 1'b1;
        tick();
        checks++;
        if (bus0.TX_REQ !== 1'b1 || bus0.TX_DATA !== 8'h3C) begin
            errors++; $display("FAIL stall_accept: got req=%b data=%h want 1 3c", bus0.TX_REQ, bus0.TX_DATA);
        end
        for (int i = 0; i < 6; i++) begin
            bus0.SRC_DATA = vals[i];
            tick();
            checks++;
            if (bus0.TX_DATA !== 8'h3C || bus0.SRC_READY !== 1'b0 || bus0.BUSY !== 1'b1) begin
                errors++; $display("FAIL stall_hold: got data=%h ready=%b busy=%b want 3c 0 1", bus0.TX_DATA, bus0.SRC_READY, bus0.BUSY);
            end
        end
        bus0.SRC_VALID = 1'b0;
        bus0.ACK_IN = 1'b1;
        n = 0;
        while (bus0.TX_REQ === 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (bus0.TX_REQ !== 1'b0 || bus0.TX_DATA !== 8'h3C) begin
            errors++; $display("FAIL stall_release: got req=%b data=%h want 0 3c", bus0.TX_REQ, bus0.TX_DATA);
        end
        bus0.ACK_IN = 1'b0;
        n = 0;
        while (bus0.DONE !== 1'b1 && n < 10) begin tick(); n++; end
        checks++;
        if (bus0.DONE !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", bus0.DONE); end
        tick();
    endtask

    task automatic test_stale_ack();
        bus0.ACK_IN = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus0.SRC_DATA = 8'hC3; bus0.SRC_VALID = 1'b1;
        tick();
        bus0.SRC_VALID = 1'b0;
        checks++;
        if (bus0.TX_REQ !== 1'b1) begin errors++; $display("FAIL stale_req_rise: got %b want 1", bus0.TX_REQ); end
        tick();
        checks++;
        if (bus0.TX_REQ !== 1'b0 || bus0.state_dbg !== S_REL) begin
            errors++; $display("FAIL stale_req_fall: got req=%b st=%0d want 0 2", bus0.TX_REQ, bus0.state_dbg);
        end
        bus0.ACK_IN = 1'b0;
        tick(); tick();
        checks++;
        if (bus0.DONE !== 1'b0) begin errors++; $display("FAIL stale_done_early: got %b want 0", bus0.DONE); end
        tick();
        checks++;
        if (bus0.DONE !== 1'b1) begin errors++; $display("FAIL stale_done: got %b want 1", bus0.DONE); end
        tick();
    endtask

    task automatic test_timeout();
        int d1, t1, req_hi;
        d1 = done1_cnt; t1 = to1_cnt; req_hi = 0;
        bus1.ACK_IN = 1'b0;
        bus1.SRC_DATA = 8'h5A; bus1.SRC_VALID = 1'b1;
        tick();
        bus1.SRC_VALID = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus1.TX_REQ === 1'b1) req_hi++;
            tick();
        end
        checks++;
        if (req_hi !== 5) begin errors++; $display("FAIL timeout_req_len: got %0d want 5", req_hi); end
        checks++;
        if (to1_cnt - t1 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d want 1", to1_cnt - t1); end
        checks++;
        if (done1_cnt - d1 !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d want 0", done1_cnt - d1); end
        checks++;
        if (bus1.state_dbg !== S_IDLE || bus1.SRC_READY !== 1'b1 || bus1.TX_DATA !== 8'h5A) begin
            errors++; $display("FAIL timeout_idle: got st=%0d ready=%b data=%h want 0 1 5a", bus1.state_dbg, bus1.SRC_READY, bus1.TX_DATA);
        end
    endtask

    task automatic test_timeout_ack_terminal();
        int d1, t1, req_hi;
        d1 = done1_cnt; t1 = to1_cnt; req_hi = 0;
        bus1.ACK_IN = 1'b0;
        bus1.SRC_DATA = 8'h6B; bus1.SRC_VALID = 1'b1;
        tick();
        bus1.SRC_VALID = 1'b0;
        // ACK_IN set after accept edge + 2 puts ack_s high exactly at the terminal edge (accept + 5)
        for (int k = 0; k < 14; k++) begin
            if (bus1.TX_REQ === 1'b1) req_hi++;
            if (k == 2) bus1.ACK_IN = 1'b1;
            if (k > 2 && bus1.TX_REQ === 1'b0) bus1.ACK_IN = 1'b0;
            tick();
        end
        checks++;
        if (req_hi !== 5) begin errors++; $display("FAIL terminal_req_len: got %0d want 5", req_hi); end
        checks++;
        if (to1_cnt - t1 !== 0) begin errors++; $display("FAIL terminal_no_timeout: got %0d want 0", to1_cnt - t1); end
        checks++;
        if (done1_cnt - d1 !== 1) begin errors++; $display("FAIL terminal_done: got %0d want 1", done1_cnt - d1); end
    endtask

    task automatic test_reset_mid();
        int d1, t1;
        bus1.ACK_IN = 1'b0;
        bus1.SRC_DATA = 8'h77; bus1.SRC_VALID = 1'b1;
        tick();
        bus1.SRC_VALID = 1'b0;
        tick();
        checks++;
        if (bus1.TX_REQ !== 1'b1) begin errors++; $display("FAIL midrst_req_before: got %b want 1", bus1.TX_REQ); end
        d1 = done1_cnt; t1 = to1_cnt;
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus1.TX_REQ !== 1'b0 || bus1.state_dbg !== S_IDLE || bus1.TX_DATA !== 8'h00) begin
            errors++; $display("FAIL midrst_cleared: got req=%b st=%0d data=%h want 0 0 00", bus1.TX_REQ, bus1.state_dbg, bus1.TX_DATA);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (done1_cnt - d1 !== 0 || to1_cnt - t1 !== 0) begin
            errors++; $display("FAIL midrst_no_pulse: got done=%0d to=%0d want 0 0", done1_cnt - d1, to1_cnt - t1);
        end
        checks++;
        if (bus1.SRC_READY !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus1.SRC_READY); end
    endtask

    initial begin
        checks = 0; errors = 0;
        done0_cnt = 0; done1_cnt = 0; to0_cnt = 0; to1_cnt = 0;
        rst_n = 1'b0;
        bus0.SRC_VALID = 1'b0; bus0.SRC_DATA = '0; bus0.ACK_IN = 1'b0;
        bus1.SRC_VALID = 1'b0; bus1.SRC_DATA = '0; bus1.ACK_IN = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_stale_ack();
        test_timeout();
        test_timeout_ack_terminal();
        test_reset_mid();
        checks++;
        if (to0_cnt !== 0) begin errors++; $display("FAIL no_timeout_when_disabled: got %0d want 0", to0_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
